// File: rtl/tlb_op_ctrl.sv
// TLB maintenance-instruction sequencer: drains outstanding memory traffic,
// issues one command to the TLB, then writes CSRs back or requests a pipeline flush.
module tlb_op_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_invtlb_op,
  input  logic [18:0] req_vppn,
  input  logic [9:0]  req_asid,
  input  logic        mem_idle,
  output logic [2:0]  tlb_op,
  output logic [4:0]  invtlb_op,
  output logic [18:0] invtlb_vppn,
  output logic [9:0]  invtlb_asid,
  output logic        csr_wr_en,
  output logic        done,
  output logic        ine,
  output logic        flush_req,
  output logic        busy
);

  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_TLBSRCH = 3'd1;
  localparam logic [2:0] OP_TLBRD   = 3'd2;
  localparam logic [2:0] OP_TLBWR   = 3'd3;
  localparam logic [2:0] OP_TLBFILL = 3'd4;
  localparam logic [2:0] OP_INVTLB  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ISSUE,
    S_WB,
    S_FLUSH
  } state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [4:0]  iop_q;
  logic [18:0] vppn_q;
  logic [9:0]  asid_q;
  logic [3:0]  drain_cnt;
  logic        done_q;

  logic [2:0]  req_op_norm;
  logic        accept;
  logic        req_illegal;
  logic        req_legal;

  // Accept-cycle decode; NONE and illegal INVTLB complete without leaving IDLE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    req_op_norm = OP_NONE;
    if (req_op >= OP_TLBSRCH && req_op <= OP_INVTLB) req_op_norm = req_op;
    req_ready   = (state == S_IDLE) && !rst;
    accept      = req_valid && req_ready;
    req_illegal = (req_op_norm == OP_INVTLB) && (req_invtlb_op > 5'd6);
    req_legal   = (req_op_norm != OP_NONE) && !req_illegal;
    ine         = accept && req_illegal;
    done        = done_q || (accept && !req_legal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_q        <= OP_NONE;
      iop_q       <= '0;
      vppn_q      <= '0;
      asid_q      <= '0;
      drain_cnt   <= '0;
      done_q      <= 1'b0;
      busy        <= 1'b0;
      tlb_op      <= OP_NONE;
      invtlb_op   <= '0;
      invtlb_vppn <= '0;
      invtlb_asid <= '0;
      csr_wr_en   <= 1'b0;
      flush_req   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      tlb_op      <= OP_NONE;
      invtlb_op   <= '0;
      invtlb_vppn <= '0;
      invtlb_asid <= '0;
      csr_wr_en   <= 1'b0;
      flush_req   <= 1'b0;
      done_q      <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= req_op_norm;
            iop_q  <= req_invtlb_op;
            vppn_q <= req_vppn;
            asid_q <= req_asid;
            if (req_legal) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
              busy      <= 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (drain_cnt != 4'hF) drain_cnt <= drain_cnt + 4'd1;
          // Outputs are registered, so the ISSUE-cycle command is loaded on this edge.
          if (mem_idle) begin
            state  <= S_ISSUE;
            tlb_op <= op_q;
            if (op_q == OP_INVTLB) begin
              invtlb_op   <= iop_q;
              invtlb_vppn <= vppn_q;
              invtlb_asid <= asid_q;
            end
            if (op_q == OP_TLBSRCH || op_q == OP_TLBRD) csr_wr_en <= 1'b1;
          end
        end

        S_ISSUE: begin
          done_q <= 1'b1;
          if (op_q == OP_TLBSRCH || op_q == OP_TLBRD) begin
            state <= S_WB;
          end else begin
            state     <= S_FLUSH;
            flush_req <= 1'b1;
          end
        end

        S_WB, S_FLUSH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed self-checking bench for tlb_op_ctrl: inputs change on the falling
// edge, outputs are sampled 1 ns later, one table of expectations per scenario.
module tb_tlb_op_ctrl;

  localparam logic [2:0] OP_NONE    = 3'd0;
  localparam logic [2:0] OP_TLBSRCH = 3'd1;
  localparam logic [2:0] OP_TLBRD   = 3'd2;
  localparam logic [2:0] OP_TLBWR   = 3'd3;
  localparam logic [2:0] OP_TLBFILL = 3'd4;
  localparam logic [2:0] OP_INVTLB  = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = OP_NONE;
  logic [4:0]  req_invtlb_op = '0;
  logic [18:0] req_vppn = '0;
  logic [9:0]  req_asid = '0;
  logic        mem_idle = 1'b1;
  logic [2:0]  tlb_op;
  logic [4:0]  invtlb_op;
  logic [18:0] invtlb_vppn;
  logic [9:0]  invtlb_asid;
  logic        csr_wr_en, done, ine, flush_req, busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tlb_op_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_invtlb_op(req_invtlb_op), .req_vppn(req_vppn), .req_asid(req_asid),
    .mem_idle(mem_idle),
    .tlb_op(tlb_op), .invtlb_op(invtlb_op), .invtlb_vppn(invtlb_vppn),
    .invtlb_asid(invtlb_asid), .csr_wr_en(csr_wr_en), .done(done), .ine(ine),
    .flush_req(flush_req), .busy(busy)
  );

  always #5 clk = ~clk;

  // {tlb_op, csr_wr_en, flush_req, done, ine, busy, req_ready, invtlb_op, vppn, asid}
  function automatic logic [42:0] obs();
    return {tlb_op, csr_wr_en, flush_req, done, ine, busy, req_ready,
            invtlb_op, invtlb_vppn, invtlb_asid};
  endfunction

  function automatic logic [42:0] ev(input logic [2:0] op, input logic csr, input logic fl,
                                     input logic dn, input logic il, input logic bz,
                                     input logic rdy);
    return {op, csr, fl, dn, il, bz, rdy, 34'd0};
  endfunction

  // The TLB must never see csr write, flush and a command together, nor commands back to back.
  logic [2:0] prev_tlb_op = OP_NONE;
  always @(negedge clk) begin
    if (!rst) begin
      total_cnt++;
      if ((tlb_op != OP_NONE && csr_wr_en && flush_req) ||
          (tlb_op != OP_NONE && prev_tlb_op != OP_NONE))
        $display("FAIL overlap: tlb_op=%0d prev=%0d csr=%b flush=%b", tlb_op, prev_tlb_op,
                 csr_wr_en, flush_req);
      else pass_cnt++;
    end
    prev_tlb_op = tlb_op;
  end

  task automatic test_reset();
    logic [42:0] e;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_INVTLB; req_invtlb_op = 5'd7;
      if (c == 2) begin rst = 1'b0; req_valid = 1'b0; end
      #1;
      e = (c == 2) ? ev(OP_NONE, 0, 0, 0, 0, 0, 1) : ev(OP_NONE, 0, 0, 0, 0, 0, 0);
      total_cnt++;
      if (obs() !== e) $display("FAIL reset cyc%0d: got %h expected %h", c, obs(), e);
      else pass_cnt++;
    end
    total_cnt++;
    if (dut.drain_cnt !== 4'd0) $display("FAIL reset_drain_cnt: got %0d expected 0", dut.drain_cnt);
    else pass_cnt++;
  endtask

  task automatic test_srch();
    logic [42:0] e;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_idle = 1'b1;
      req_valid = (c == 0); req_op = OP_TLBSRCH;
      #1;
      case (c)
        0:       e = ev(OP_NONE,    0, 0, 0, 0, 0, 1);
        1:       e = ev(OP_NONE,    0, 0, 0, 0, 1, 0);
        2:       e = ev(OP_TLBSRCH, 1, 0, 0, 0, 1, 0);
        3:       e = ev(OP_NONE,    0, 0, 1, 0, 1, 0);
        default: e = ev(OP_NONE,    0, 0, 0, 0, 0, 1);
      endcase
      total_cnt++;
      if (obs() !== e) $display("FAIL srch cyc%0d: got %h expected %h", c, obs(), e);
      else pass_cnt++;
    end
  endtask

  task automatic test_wr_drain();
    logic [42:0] e;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 6) begin
        total_cnt++;
        if (dut.drain_cnt !== 4'd5) $display("FAIL drain_cnt: got %0d expected 5", dut.drain_cnt);
        else pass_cnt++;
      end
      req_valid = (c == 0) || (c >= 1 && c <= 7);
      req_op    = (c == 0) ? OP_TLBWR : OP_TLBSRCH;
      mem_idle  = (c == 6);
      #1;
      case (c)
        0:       e = ev(OP_NONE,  0, 0, 0, 0, 0, 1);
        7:       e = ev(OP_TLBWR, 0, 0, 0, 0, 1, 0);
        8:       e = ev(OP_NONE,  0, 1, 1, 0, 1, 0);
        9:       e = ev(OP_NONE,  0, 0, 0, 0, 0, 1);
        default: e = ev(OP_NONE,  0, 0, 0, 0, 1, 0);
      endcase
      total_cnt++;
      if (obs() !== e) $display("FAIL wr_drain cyc%0d: got %h expected %h", c, obs(), e);
      else pass_cnt++;
    end
    mem_idle = 1'b1;
  endtask

  task automatic test_invtlb();
    logic [42:0] e;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_idle = 1'b1;
      req_valid = (c == 0); req_op = OP_INVTLB;
      if (c == 0) begin req_invtlb_op = 5'd5; req_vppn = 19'h12345; req_asid = 10'h03A; end
      else        begin req_invtlb_op = 5'd2; req_vppn = 19'h7FFFF; req_asid = 10'h111; end
      #1;
      case (c)
        0:       e = ev(OP_NONE,   0, 0, 0, 0, 0, 1);
        1:       e = ev(OP_NONE,   0, 0, 0, 0, 1, 0);
        2:       e = ev(OP_INVTLB, 0, 0, 0, 0, 1, 0) | {9'd0, 5'd5, 19'h12345, 10'h03A};
        3:       e = ev(OP_NONE,   0, 1, 1, 0, 1, 0);
        default: e = ev(OP_NONE,   0, 0, 0, 0, 0, 1);
      endcase
      total_cnt++;
      if (obs() !== e) $display("FAIL invtlb cyc%0d: got %h expected %h", c, obs(), e);
      else pass_cnt++;
    end
  endtask

  task automatic test_ine_none();
    logic [42:0] e;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      mem_idle = 1'b1;
      req_valid = (c == 0 || c == 1 || c == 3 || c == 5);
      case (c)
        0:       begin req_op = OP_INVTLB; req_invtlb_op = 5'd7; end
        1:       begin req_op = OP_NONE;   req_invtlb_op = 5'd0; end
        3:       begin req_op = 3'd7;      req_invtlb_op = 5'd0; end
        5:       begin req_op = OP_INVTLB; req_invtlb_op = 5'd6;
                       req_vppn = 19'd0; req_asid = 10'h3FF; end
        default: req_op = OP_NONE;
      endcase
      #1;
      case (c)
        0:       e = ev(OP_NONE,   0, 0, 1, 1, 0, 1);
        1, 3:    e = ev(OP_NONE,   0, 0, 1, 0, 0, 1);
        5:       e = ev(OP_NONE,   0, 0, 0, 0, 0, 1);
        6:       e = ev(OP_NONE,   0, 0, 0, 0, 1, 0);
        7:       e = ev(OP_INVTLB, 0, 0, 0, 0, 1, 0) | {9'd0, 5'd6, 19'd0, 10'h3FF};
        8:       e = ev(OP_NONE,   0, 1, 1, 0, 1, 0);
        default: e = ev(OP_NONE,   0, 0, 0, 0, 0, 1);
      endcase
      total_cnt++;
      if (obs() !== e) $display("FAIL ine_none cyc%0d: got %h expected %h", c, obs(), e);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [42:0] e;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      mem_idle  = 1'b1;
      req_valid = (c <= 4);
      req_op    = (c == 0) ? OP_TLBFILL : OP_TLBRD;
      #1;
      case (c)
        0:       e = ev(OP_NONE,    0, 0, 0, 0, 0, 1);
        1:       e = ev(OP_NONE,    0, 0, 0, 0, 1, 0);
        2:       e = ev(OP_TLBFILL, 0, 0, 0, 0, 1, 0);
        3:       e = ev(OP_NONE,    0, 1, 1, 0, 1, 0);
        4:       e = ev(OP_NONE,    0, 0, 0, 0, 0, 1);
        5:       e = ev(OP_NONE,    0, 0, 0, 0, 1, 0);
        6:       e = ev(OP_TLBRD,   1, 0, 0, 0, 1, 0);
        7:       e = ev(OP_NONE,    0, 0, 1, 0, 1, 0);
        default: e = ev(OP_NONE,    0, 0, 0, 0, 0, 1);
      endcase
      total_cnt++;
      if (obs() !== e) $display("FAIL back_to_back cyc%0d: got %h expected %h", c, obs(), e);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_abort();
    logic [42:0] e;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req_valid = (c == 0); req_op = OP_TLBWR;
      mem_idle  = (c >= 4);
      if (c == 2) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      #1;
      case (c)
        0:       e = ev(OP_NONE, 0, 0, 0, 0, 0, 1);
        1:       e = ev(OP_NONE, 0, 0, 0, 0, 1, 0);
        2, 3:    e = ev(OP_NONE, 0, 0, 0, 0, 0, 0);
        default: e = ev(OP_NONE, 0, 0, 0, 0, 0, 1);
      endcase
      total_cnt++;
      if (obs() !== e) $display("FAIL reset_abort cyc%0d: got %h expected %h", c, obs(), e);
      else pass_cnt++;
      if (c == 3) begin
        total_cnt++;
        if (dut.drain_cnt !== 4'd0)
          $display("FAIL reset_abort_drain_cnt: got %0d expected 0", dut.drain_cnt);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_srch();
    test_wr_drain();
    test_invtlb();
    test_ine_none();
    test_back_to_back();
    test_reset_abort();
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-002 The block SHALL have port req_valid, input, 1 bit: a TLB instruction is presented by the MEM stage.
REQ-003 The block SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-004 The block SHALL have port req_op, input, tlb_op_t: TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB; any other value is NONE.
REQ-005 The block SHALL have ports req_invtlb_op (input, 5 bits), req_vppn (input, vppn_t, 19 bits) and req_asid (input, asid_t, 10 bits): INVTLB operands.
REQ-006 The block SHALL have port mem_idle, input, 1 bit: no outstanding load, store or fetch uses a TLB lookup.
REQ-007 The block SHALL have ports tlb_op (output, tlb_op_t), invtlb_op (output, 5 bits), invtlb_vppn (output, 19 bits) and invtlb_asid (output, 10 bits): the command driven to the TLB.
REQ-008 The block SHALL have port csr_wr_en, output, 1 bit: gates the TLB-to-CSR write request.
REQ-009 The block SHALL have ports done (output, 1 bit, one-cycle completion pulse) and ine (output, 1 bit, one-cycle pulse for an illegal invtlb_op).
REQ-010 The block SHALL have port flush_req, output, 1 bit: pipeline flush/refetch request after a TLB modification.
REQ-011 The block SHALL have port busy, output, 1 bit: the FSM is not IDLE; the pipeline holds younger instructions.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, DRAIN, ISSUE, WB, FLUSH.
REQ-013 req_ready SHALL equal 1 only in IDLE, and a request is accepted when req_valid and req_ready are both 1.
REQ-014 On acceptance, the op and all operands SHALL be latched, and outputs SHALL use only the latched copies afterwards.
REQ-015 On acceptance of an INVTLB with invtlb_op > 6, the block SHALL pulse ine for 1 cycle, pulse done in the same cycle, stay in IDLE and issue nothing to the TLB.
REQ-016 On acceptance of a NONE op, the block SHALL pulse done in the same cycle and stay in IDLE.
REQ-017 On acceptance of a legal op, IDLE SHALL go to DRAIN.
REQ-018 In DRAIN, when mem_idle is 1, the FSM SHALL go to ISSUE on the next edge; otherwise it SHALL stay in DRAIN.
REQ-019 A 4-bit drain counter SHALL increment each DRAIN cycle, saturate at 15 and clear on entry to DRAIN; it SHALL be readable only as the internal drain_cnt for verification and SHALL have no functional effect.
REQ-020 In ISSUE, tlb_op SHALL equal the latched op for exactly 1 cycle; in every other state tlb_op SHALL be NONE.
REQ-021 In ISSUE for INVTLB, invtlb_op, invtlb_vppn and invtlb_asid SHALL equal the latched values; in all other cycles they SHALL be 0.
REQ-022 In ISSUE for TLBSRCH or TLBRD, csr_wr_en SHALL be 1 and the next state SHALL be WB.
REQ-023 In ISSUE for TLBWR, TLBFILL or INVTLB, the next state SHALL be FLUSH.
REQ-024 WB SHALL last 1 cycle, pulse done, and return to IDLE; no flush is issued for TLBSRCH or TLBRD.
REQ-025 FLUSH SHALL last 1 cycle, with flush_req=1 and done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in DRAIN, ISSUE, WB and FLUSH, and 0 in IDLE.
REQ-027 End-to-end latency with mem_idle already 1 SHALL be: accept at cycle 0; ISSUE at cycle 2; done at cycle 3.
REQ-028 The block SHALL never drive tlb_op, csr_wr_en and flush_req together in one cycle; tlb_op is never driven in consecutive cycles.
REQ-029 req_valid or operand changes while not in IDLE SHALL be ignored.
REQ-030 mem_idle falling after DRAIN has been left SHALL have no effect on the operation in progress.

Reset
REQ-031 While rst=1, the state SHALL be IDLE, all latches and drain_cnt 0; req_ready=1 only after rst deasserts, and 0 while rst=1.
REQ-032 While rst=1, the outputs tlb_op=NONE, invtlb_*=0, csr_wr_en=0, done=0, ine=0, flush_req=0 and busy=0 SHALL hold.
REQ-033 Reset asserted in any state, including between ISSUE and WB or FLUSH, SHALL abort the operation without a done or flush pulse; the TLB update committed in ISSUE remains.

Verification
REQ-034 TLBSRCH with mem_idle=1 -> tlb_op=TLBSRCH and csr_wr_en=1 at cycle 2; done at cycle 3; flush_req stays 0.
REQ-035 TLBWR with mem_idle=0 for 5 cycles -> DRAIN holds with drain_cnt=5; ISSUE 1 cycle after mem_idle rises; flush_req and done together 1 cycle later.
REQ-036 INVTLB with op=5, asid=0x3A, vppn=0x12345 -> invtlb_* carry those values only in the ISSUE cycle; then FLUSH.
REQ-037 INVTLB with op=7 -> ine=1 and done=1 in the accept cycle; tlb_op stays NONE; busy stays 0.
REQ-038 Back-to-back TLBFILL then TLBRD with req_valid held high -> the second request is accepted only in the cycle after FLUSH; no overlap of tlb_op.
REQ-039 rst pulsed during DRAIN of a TLBWR -> no tlb_op, done or flush issued; req_ready=1 after rst deasserts.
